transpose_ctrl: RTL and testbench

- Sequencing controller for the 8x8x12-bit transpose buffer between the row-pass and column-pass 1-D DCT stages of the JPEG datapath.
- Turns a valid/ready row stream into the buffer's wr/rd strobes: 8 row writes (FILL), then 8 column reads (DRAIN).
- Exposes a valid/ready column stream downstream.
- Carries control only. The 96-bit row and column data connect directly between the DCT stages and the buffer.

---
 rtl/jpeg_pkg.sv | 21 ++
 rtl/transpose_ctrl.sv | 138 +++++++++++++
 tb/tb_transpose_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/jpeg_pkg.sv
// Shared JPEG datapath types: transpose-buffer geometry, controller state and perf-counter helper.
package jpeg_pkg;

    localparam int unsigned TP_N   = 8;
    localparam int unsigned TP_W   = 12;
    localparam int unsigned TP_CW  = $clog2(TP_N);
    localparam int unsigned PERF_W = 16;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } tp_state_t;

    // One 8-coefficient row (or column) as seen at the transpose buffer ports.
    typedef logic [TP_N-1:0][TP_W-1:0] tp_row_t;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + PERF_W'(1);
    endfunction

endpackage

// File: rtl/transpose_ctrl.sv
// Write/read sequencer for the 8x8 transpose buffer between the DCT row and column passes.
// Optional perf counters are built only when TRANSPOSE_CTRL_PERF_EN is defined.
module transpose_ctrl
    import jpeg_pkg::*;
#(
    parameter int unsigned N  = TP_N,
    parameter int unsigned CW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              tp_wr,
    output logic              tp_rd,
    output logic              busy,
    output logic              blk_done,
    output logic [PERF_W-1:0] perf_blocks,
    output logic [PERF_W-1:0] perf_stall
);

    tp_state_t       state_q, state_d;
    logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]   out_cnt_q, out_cnt_d;
    logic            out_valid_q, out_valid_d;
    logic            blk_done_q, blk_done_d;
    logic            col_hs;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            out_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            blk_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            out_cnt_q   <= out_cnt_d;
            out_valid_q <= out_valid_d;
            blk_done_q  <= blk_done_d;
        end
    end

    // Strobes are decoded from state; reads only fire when the output register can take a new column.
    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        out_cnt_d   = out_cnt_q;
        out_valid_d = out_valid_q;
        blk_done_d  = 1'b0;
        in_ready    = 1'b0;
        tp_wr       = 1'b0;
        tp_rd       = 1'b0;
        col_hs      = out_valid_q && out_ready;

        unique case (state_q)
            FILL: begin
                in_ready = 1'b1;
                tp_wr    = in_valid;
                if (tp_wr) begin
                    wr_cnt_d = wr_cnt_q + CW'(1);
                    if (wr_cnt_q == CW'(N - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                tp_rd = !out_valid_q || out_ready;
                if (tp_rd) begin
                    rd_cnt_d = rd_cnt_q + CW'(1);
                    if (rd_cnt_q == CW'(N - 1)) begin
                        state_d = FILL;
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase

        if (tp_rd) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (col_hs) begin
            out_cnt_d = out_cnt_q + CW'(1);
            if (out_cnt_q == CW'(N - 1)) begin
                blk_done_d = 1'b1;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign blk_done  = blk_done_q;
    assign busy      = (wr_cnt_q != '0) || (state_q == DRAIN) || out_valid_q;

`ifdef TRANSPOSE_CTRL_PERF_EN
    logic [PERF_W-1:0] perf_blocks_q, perf_blocks_d;
    logic [PERF_W-1:0] perf_stall_q, perf_stall_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_blocks_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_blocks_q <= perf_blocks_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    // Saturating: a stuck downstream must not wrap the stall count back to a small value.
    always_comb begin
        perf_blocks_d = perf_blocks_q;
        perf_stall_d  = perf_stall_q;
        if (blk_done_q) begin
            perf_blocks_d = sat_inc(perf_blocks_q);
        end
        if (out_valid_q && !out_ready) begin
            perf_stall_d = sat_inc(perf_stall_q);
        end
    end

    assign perf_blocks = perf_blocks_q;
    assign perf_stall  = perf_stall_q;
`else
    assign perf_blocks = '0;
    assign perf_stall  = '0;
`endif

endmodule

// File: tb/tb_transpose_ctrl.sv
// Bench for transpose_ctrl: directed timing checks plus a column scoreboard fed by a buffer model.
module tb_transpose_ctrl;
    import jpeg_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic        tp_wr;
    logic        tp_rd;
    logic        busy;
    logic        blk_done;
    logic [15:0] perf_blocks;
    logic [15:0] perf_stall;

    always #5 clk = ~clk;

    transpose_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .tp_wr       (tp_wr),
        .tp_rd       (tp_rd),
        .busy        (busy),
        .blk_done    (blk_done),
        .perf_blocks (perf_blocks),
        .perf_stall  (perf_stall)
    );

    // Behavioural transpose buffer: rd has priority, output register holds while rd=0.
    tp_row_t    row_in;
    tp_row_t    col_out;
    tp_row_t    mem [TP_N];
    logic [2:0] bwr;
    logic [2:0] brd;

    always @(posedge clk) begin
        if (rst) begin
            bwr     <= 3'd0;
            brd     <= 3'd0;
            col_out <= '0;
        end else if (tp_rd) begin
            for (int i = 0; i < TP_N; i++) col_out[i] <= mem[i][brd];
            brd <= brd + 3'd1;
        end else if (tp_wr) begin
            mem[bwr] <= row_in;
            bwr      <= bwr + 3'd1;
        end
    end

    int      n_checks = 0;
    int      n_pass   = 0;
    int      blk_cnt  = 0;
    int      pops     = 0;
    bit      rnd_en   = 1'b0;
    tp_row_t exp_q[$];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic tp_row_t mk_row(input int b, input int r);
        tp_row_t v;
        for (int c = 0; c < TP_N; c++) v[c] = 12'((b << 8) | (r << 4) | c);
        return v;
    endfunction

    // Column j of block b: element i is row i, coefficient j.
    function automatic tp_row_t mk_col(input int b, input int j);
        tp_row_t v;
        for (int i = 0; i < TP_N; i++) v[i] = 12'((b << 8) | (i << 4) | j);
        return v;
    endfunction

    task automatic push_block(input int b);
        for (int j = 0; j < TP_N; j++) exp_q.push_back(mk_col(b, j));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rows(input int b, input int nrows);
        for (int r = 0; r < nrows; r++) begin
            in_valid = 1'b1;
            row_in   = mk_row(b, r);
            next_cycle();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_checks++;
            $display("FAIL %s: busy still %0d after %0d cycles", name, busy, budget);
        end
        next_cycle();
    endtask

    // Scoreboard monitor and strobe-exclusion check.
    always @(negedge clk) begin
        if (!rst) begin
            check("wr_rd_exclusive", 96'(tp_wr & tp_rd), 96'(0));
            if (blk_done) blk_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_underflow: got column %0h expected none", col_out);
                end else begin
                    check("column", col_out, exp_q.pop_front());
                    pops++;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_en) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int          wr_seen;
        int          k;
        int          n;
        logic [15:0] base;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        row_in    = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_ctl", 96'({in_ready, busy, out_valid, blk_done, tp_wr, tp_rd}), 96'(6'b100000));
        check("rst_perf", 96'({perf_blocks, perf_stall}), 96'(0));
        next_cycle();

        // Block 1: eight consecutive rows, downstream always ready.
        push_block(1);
        out_ready = 1'b1;
        for (int c = 0; c < 18; c++) begin
            in_valid = (c < 8);
            row_in   = (c < 8) ? mk_row(1, c) : '0;
            @(negedge clk);
            check($sformatf("t1_ctl_c%0d", c),
                  96'({tp_wr, tp_rd, out_valid, in_ready, blk_done}),
                  96'({c < 8, c >= 8 && c < 16, c >= 9 && c <= 16, !(c >= 8 && c < 16), c == 17}));
            if (c == 4)  check("t1_busy_mid", 96'(busy), 96'(1));
            if (c == 17) check("t1_busy_end", 96'(busy), 96'(0));
            next_cycle();
        end
        check("t1_blk_cnt", 96'(blk_cnt), 96'(1));

        // Block 2: five stall cycles right after the first column appears.
        base = perf_stall;
        push_block(2);
        send_rows(2, 8);
        @(negedge clk);
        check("t2_first_rd", 96'(tp_rd), 96'(1));
        next_cycle();
        out_ready = 1'b0;
        for (int c = 9; c < 14; c++) begin
            @(negedge clk);
            check($sformatf("t2_stall_c%0d", c), 96'({out_valid, tp_rd}), 96'(2'b10));
            check($sformatf("t2_hold_c%0d", c), col_out, mk_col(2, 0));
            next_cycle();
        end
        out_ready = 1'b1;
        wait_idle("t2_drain", 40);
        next_cycle();
`ifdef TRANSPOSE_CTRL_PERF_EN
        check("t2_perf_stall", 96'(perf_stall - base), 96'(5));
`endif
        check("t2_blk_cnt", 96'(blk_cnt), 96'(2));

        // Block 3: in_valid alternating, eight writes spread over fifteen cycles.
        push_block(3);
        wr_seen = 0;
        for (int c = 0; c < 15; c++) begin
            in_valid = (c % 2 == 0);
            row_in   = mk_row(3, c / 2);
            @(negedge clk);
            check($sformatf("t3_fill_c%0d", c), 96'({tp_wr, in_ready, tp_rd}), 96'({in_valid, 1'b1, 1'b0}));
            if (tp_wr) wr_seen++;
            next_cycle();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("t3_drain_entry", 96'({in_ready, tp_rd}), 96'(2'b01));
        check("t3_writes", 96'(wr_seen), 96'(8));
        next_cycle();
        wait_idle("t3_drain", 40);
        check("t3_blk_cnt", 96'(blk_cnt), 96'(3));

        // Reset after four rows drops the partial block.
        send_rows(9, 4);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("t4_after_rst", 96'({busy, in_ready, out_valid, blk_done}), 96'(4'b0100));
`ifdef TRANSPOSE_CTRL_PERF_EN
        check("t4_perf_clr", 96'({perf_blocks, perf_stall}), 96'(0));
`endif
        next_cycle();
        push_block(4);
        send_rows(4, 8);
        wait_idle("t4_drain", 40);
        check("t4_blk_cnt", 96'(blk_cnt), 96'(4));

        // Block 5: in_valid held high throughout the drain.
        push_block(5);
        send_rows(5, 8);
        for (int c = 8; c < 16; c++) begin
            in_valid = 1'b1;
            row_in   = mk_row(15, 15);
            @(negedge clk);
            check($sformatf("t6_drain_c%0d", c), 96'({in_ready, tp_wr, tp_rd}), 96'(3'b001));
            next_cycle();
        end
        in_valid = 1'b0;
        wait_idle("t6_drain", 40);
        next_cycle();
        check("t6_blk_cnt", 96'(blk_cnt), 96'(5));

        // Blocks 6..8 back-to-back with random downstream backpressure.
        base   = perf_blocks;
        rnd_en = 1'b1;
        k = 0;
        n = 0;
        while (k < 24 && n < 600) begin
            in_valid = 1'b1;
            row_in   = mk_row(6 + k / 8, k % 8);
            @(negedge clk);
            if (in_ready) begin
                if (k % 8 == 0) push_block(6 + k / 8);
                k++;
            end
            n++;
            next_cycle();
        end
        in_valid = 1'b0;
        check("t5_rows_accepted", 96'(k), 96'(24));
        wait_idle("t5_drain", 400);
        rnd_en = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        next_cycle();
`ifdef TRANSPOSE_CTRL_PERF_EN
        check("t5_perf_blocks", 96'(perf_blocks - base), 96'(3));
`else
        check("perf_tied_off", 96'({perf_blocks, perf_stall, base}), 96'(0));
`endif
        check("t5_blk_cnt", 96'(blk_cnt), 96'(8));
        check("total_columns", 96'(pops), 96'(64));
        check("sb_empty", 96'(exp_q.size()), 96'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
